bcd_disp_ctrl: RTL and testbench

Sequencing controller for the 4-digit multiplexed seven-segment display. It accepts a binary result, such as the multiplier product, through a start strobe and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine. It holds the last completed value and scans it across the four digit enables. Per-digit segment decoding stays in the external `seven_segment` decoder, which is driven from `digit`.

---
 rtl/bcd_disp_ctrl_if.sv | 15 +
 rtl/bcd_disp_ctrl.sv | 99 +++++++++
 tb/tb_bcd_disp_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bcd_disp_ctrl_if.sv
// Request/display bundle for bcd_disp_ctrl: start/bin in, conversion status and
// multiplexed digit drive out.
interface bcd_disp_ctrl_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] bin;
  logic         blank_lz;
  logic         busy;
  logic         done;
  logic [15:0]  bcd;
  logic [3:0]   EN;
  logic [3:0]   digit;

  modport master (output start, bin, blank_lz, input busy, done, bcd, EN, digit);
  modport slave  (input start, bin, blank_lz, output busy, done, bcd, EN, digit);
endinterface

// File: rtl/bcd_disp_ctrl.sv
// Binary to packed-BCD converter (one shift-add-3 step per cycle) feeding a
// 4-digit multiplexed seven-segment scan with optional leading-zero blanking.
module bcd_disp_ctrl #(
  parameter int W         = 8,
  parameter int SCAN_BITS = 16
) (
  input  logic          clk,
  input  logic          clr,
  bcd_disp_ctrl_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                r_state;
  logic [W-1:0]          r_shift;
  logic [15:0]           r_scr;
  logic [15:0]           r_bcd;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [SCAN_BITS-1:0]  r_scan;

  logic [15:0] w_adj;
  logic [15:0] w_scr_nxt;
  logic [1:0]  w_slot;
  logic [3:0]  w_en;
  logic [3:0]  w_digit;
  logic        w_blank;

  // Add-3 on every nibble >= 5, then shift the next binary bit in.
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < 4; i++) begin
      if (r_scr[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
    end
    w_scr_nxt = (w_adj << 1) | 16'(r_shift[W-1]);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_scr   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_scan  <= '0;
    end else begin
      r_scan <= r_scan + SCAN_BITS'(1);
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shift <= bus.bin;
            r_scr   <= '0;
            r_cnt   <= CW'(W);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_scr   <= w_scr_nxt;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_bcd   <= w_scr_nxt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign w_slot = r_scan[SCAN_BITS-1 -: 2];

  // A slot blanks only if it and every more significant nibble are zero.
  always_comb begin
    w_digit = r_bcd[3:0];
    w_blank = 1'b0;
    case (w_slot)
      2'd0: begin w_digit = r_bcd[15:12]; w_blank = (r_bcd[15:12] == 4'd0); end
      2'd1: begin w_digit = r_bcd[11:8];  w_blank = (r_bcd[15:8]  == 8'd0); end
      2'd2: begin w_digit = r_bcd[7:4];   w_blank = (r_bcd[15:4]  == 12'd0); end
      2'd3: begin w_digit = r_bcd[3:0];   w_blank = 1'b0; end
    endcase
    w_en = 4'b1000 >> w_slot;
    if (bus.blank_lz && w_blank) w_en = 4'b0000;
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.bcd   = r_bcd;
  assign bus.EN    = w_en;
  assign bus.digit = w_digit;
endmodule

// File: tb/tb_bcd_disp_ctrl.sv
// Directed checks of bcd_disp_ctrl: reset, conversion latency, ignored and
// back-to-back starts, scan order, leading-zero blanking and mid-op reset.
module tb_bcd_disp_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] sc = '0;  // expected scan counter (SCAN_BITS=4)
  int   ndone;

  always #5 clk = ~clk;

  bcd_disp_ctrl_if #(.W(8))  b8 ();
  bcd_disp_ctrl_if #(.W(13)) b13 ();

  bcd_disp_ctrl #(.W(8),  .SCAN_BITS(4)) u8  (.clk(clk), .clr(clr), .bus(b8));
  bcd_disp_ctrl #(.W(13), .SCAN_BITS(4)) u13 (.clk(clk), .clr(clr), .bus(b13));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sc = sc + 4'd1;
  endtask

  task automatic conv8(input logic [7:0] v, input logic [15:0] exp, input string tag);
    b8.bin = v; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    chk({tag, "_busy_t0"}, b8.busy, 1);
    repeat (7) begin
      tick();
      chk({tag, "_busy_mid"}, {b8.busy, b8.done}, 2'b10);
    end
    tick();
    chk({tag, "_done"}, {b8.busy, b8.done}, 2'b01);
    chk({tag, "_bcd"}, b8.bcd, exp);
    tick();
    chk({tag, "_done_drop"}, b8.done, 0);
  endtask

  task automatic conv13(input logic [12:0] v, input logic [15:0] exp, input string tag);
    b13.bin = v; b13.start = 1'b1;
    tick();
    b13.start = 1'b0;
    chk({tag, "_busy_t0"}, b13.busy, 1);
    repeat (12) tick();
    tick();
    chk({tag, "_done"}, {b13.busy, b13.done}, 2'b01);
    chk({tag, "_bcd"}, b13.bcd, exp);
  endtask

  // en_tab/dig_tab list slot0..slot3 from the top nibble down.
  task automatic scan_chk(input string tag, input logic [15:0] en_tab, input logic [15:0] dig_tab);
    int s;
    for (int k = 0; k < 16; k++) begin
      tick();
      s = int'(sc[3:2]);
      chk({tag, "_en"},    b13.EN,    en_tab[4*(3-s) +: 4]);
      chk({tag, "_digit"}, b13.digit, dig_tab[4*(3-s) +: 4]);
    end
  endtask

  initial begin
    b8.start = 0;  b8.bin = '0;  b8.blank_lz = 0;
    b13.start = 0; b13.bin = '0; b13.blank_lz = 0;

    // asynchronous reset mid-cycle
    #7 clr = 1'b1;
    #1;
    chk("rst_busy",  b8.busy, 0);
    chk("rst_done",  b8.done, 0);
    chk("rst_bcd",   b8.bcd, 16'h0000);
    chk("rst_en",    b8.EN, 4'b1000);
    chk("rst_digit", b8.digit, 4'h0);
    b8.blank_lz = 1'b1;
    #1;
    chk("rst_en_blank", b8.EN, 4'b0000);
    @(posedge clk); #1;
    clr = 1'b0; sc = '0; b8.blank_lz = 1'b0;

    conv8(8'd255, 16'h0255, "c255");
    conv8(8'd0,   16'h0000, "c0");

    // start during SHIFT is ignored
    b8.bin = 8'd200; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    ndone = 0;
    tick(); ndone += int'(b8.done);
    tick(); ndone += int'(b8.done);
    b8.bin = 8'd17; b8.start = 1'b1;
    tick(); ndone += int'(b8.done);
    b8.start = 1'b0;
    repeat (4) begin tick(); ndone += int'(b8.done); end
    tick(); ndone += int'(b8.done);
    chk("ign_done", b8.done, 1);
    chk("ign_bcd",  b8.bcd, 16'h0200);
    chk("ign_ndone", ndone, 1);
    // start in the done cycle is accepted
    b8.bin = 8'd17; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    chk("b2b_busy", {b8.busy, b8.done}, 2'b10);
    repeat (7) tick();
    tick();
    chk("b2b_done", b8.done, 1);
    chk("b2b_bcd",  b8.bcd, 16'h0017);
    tick();

    // scan order and digit mux
    conv13(13'd1234, 16'h1234, "c1234");
    scan_chk("scan1234", 16'h8421, 16'h1234);

    // leading-zero blanking
    b13.blank_lz = 1'b1;
    conv13(13'd7, 16'h0007, "c7");
    scan_chk("blank7", 16'h0001, 16'h0007);
    conv13(13'd8191, 16'h8191, "c8191");
    scan_chk("blank8191", 16'h8421, 16'h8191);
    conv13(13'd1005, 16'h1005, "c1005");
    scan_chk("blank1005", 16'h8421, 16'h1005);

    // reset during SHIFT aborts the conversion
    b8.bin = 8'd200; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    tick(); tick(); tick();
    #4 clr = 1'b1;
    #1;
    chk("mid_rst_busy",  b8.busy, 0);
    chk("mid_rst_bcd",   b8.bcd, 16'h0000);
    chk("mid_rst_en",    b8.EN, 4'b1000);
    chk("mid_rst_digit", b8.digit, 4'h0);
    @(posedge clk); #1;
    clr = 1'b0; sc = '0;
    repeat (10) begin
      tick();
      chk("mid_rst_idle", {b8.busy, b8.done}, 2'b00);
    end
    chk("mid_rst_bcd_hold", b8.bcd, 16'h0000);
    conv8(8'd99, 16'h0099, "c99");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
